// File: rtl/reg_pkg.sv
// Shared constants and width helpers for the register-file write port controller.
package reg_pkg;

  localparam int unsigned NUM_CH_DEF   = 2;
  localparam int unsigned NUM_REGS_DEF = 16;
  localparam int unsigned CNT_W_DEF    = 16;

  // Width needed to encode n distinct values, never less than one bit.
  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned ID_W_DEF = id_width(NUM_REGS_DEF);

endpackage

// File: rtl/reg_id_decoder.sv
// Combinational register-ID to one-hot wordline decode with out-of-range flag.
// IDs >= NUM_REGS produce an all-zero one-hot and raise range_err.
module reg_id_decoder #(
  parameter int unsigned NUM_REGS = 16,
  parameter int unsigned ID_W     = 4
) (
  input  logic [ID_W-1:0]     id,
  output logic [NUM_REGS-1:0] onehot,
  output logic                range_err
);

  // One bit per addressable register; unmatched IDs leave every bit clear.
  always_comb begin
    onehot = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      onehot[i] = (32'(id) == i);
    end
    range_err = (32'(id) >= NUM_REGS);
  end

endmodule

// File: rtl/reg_write_port_ctrl.sv
// Multi-channel register-file write port controller.
// Each channel's accepted request is decoded to a one-hot wordline, registered
// for exactly one cycle. Requests to the same register are arbitrated
// round-robin; a loser waits in a one-entry per-channel hold buffer.
// Optional build macro: R0_READONLY_EN (register 0 is hardwired zero: writes
// to ID 0 complete immediately with no wordline, no error and no conflict).
module reg_write_port_ctrl
  import reg_pkg::*;
#(
  parameter int unsigned NUM_CH   = NUM_CH_DEF,
  parameter int unsigned NUM_REGS = NUM_REGS_DEF,
  parameter int unsigned ID_W     = id_width(NUM_REGS),
  parameter int unsigned CNT_W    = CNT_W_DEF
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_CH-1:0]            wr_valid,
  input  logic [NUM_CH*ID_W-1:0]       wr_id,
  output logic [NUM_CH-1:0]            wr_ready,
  output logic [NUM_CH*NUM_REGS-1:0]   wordline,
  output logic [NUM_CH-1:0]            wl_valid,
  output logic [NUM_CH-1:0]            id_err,
  output logic [CNT_W-1:0]             conflict_cnt
);

  localparam int unsigned PTR_W = id_width(NUM_CH);

  logic [NUM_CH-1:0]   hold_vld;
  logic [ID_W-1:0]     hold_id [NUM_CH];
  logic [PTR_W-1:0]    rr_ptr;

  logic [NUM_CH-1:0]   accept;
  logic [NUM_CH-1:0]   cand_raw;
  logic [NUM_CH-1:0]   cand_v;
  logic [NUM_CH-1:0]   cand_err;
  logic [NUM_CH-1:0]   dec_err;
  logic [NUM_CH-1:0]   lose;
  logic [NUM_CH-1:0]   grant;
  logic [ID_W-1:0]     cand_id [NUM_CH];
  logic [NUM_REGS-1:0] cand_oh [NUM_CH];
  logic                any_loss;
  logic [PTR_W-1:0]    rr_next;
  logic                best_found;
  logic [ID_W-1:0]     best_id;
  logic                group_loss;

  // Round-robin priority distance of a channel from the current pointer.
  function automatic int unsigned rr_dist(input int unsigned ch, input logic [PTR_W-1:0] ptr);
    return (ch + NUM_CH - 32'(ptr)) % NUM_CH;
  endfunction

  // Ready while out of reset and the channel's hold buffer is empty.
  assign wr_ready = {NUM_CH{rst_n}} & ~hold_vld;
  assign accept   = wr_valid & wr_ready;

  // Per-channel candidate: held request first, otherwise a newly accepted one.
  always_comb begin
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      cand_raw[c] = hold_vld[c] | accept[c];
      cand_id[c]  = hold_vld[c] ? hold_id[c] : wr_id[c*ID_W +: ID_W];
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_dec
    reg_id_decoder #(
      .NUM_REGS (NUM_REGS),
      .ID_W     (ID_W)
    ) u_dec (
      .id        (cand_id[g]),
      .onehot    (cand_oh[g]),
      .range_err (dec_err[g])
    );
  end

  // Drop out-of-range candidates (and ID 0 when it is read-only).
  always_comb begin
    cand_err = cand_raw & dec_err;
    cand_v   = cand_raw & ~dec_err;
`ifdef R0_READONLY_EN
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (cand_id[c] == '0) begin
        cand_v[c] = 1'b0;
      end
    end
`endif
  end

  // A candidate loses if another candidate with the same ID has higher priority.
  always_comb begin
    lose = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      for (int unsigned d = 0; d < NUM_CH; d++) begin
        if ((d != c) && cand_v[c] && cand_v[d] && (cand_id[d] == cand_id[c]) &&
            (rr_dist(d, rr_ptr) < rr_dist(c, rr_ptr))) begin
          lose[c] = 1'b1;
        end
      end
    end
    grant    = cand_v & ~lose;
    any_loss = |lose;
  end

  // Next pointer follows the winner of the lowest-ID group that had a loss.
  always_comb begin
    rr_next    = rr_ptr;
    best_found = 1'b0;
    best_id    = '0;
    group_loss = 1'b0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      group_loss = 1'b0;
      for (int unsigned d = 0; d < NUM_CH; d++) begin
        if (lose[d] && (cand_id[d] == cand_id[c])) begin
          group_loss = 1'b1;
        end
      end
      if (grant[c] && group_loss && (!best_found || (cand_id[c] < best_id))) begin
        best_found = 1'b1;
        best_id    = cand_id[c];
        rr_next    = PTR_W'((c + 1) % NUM_CH);
      end
    end
  end

  // Registered wordlines, error pulses, hold buffers, pointer and conflict counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wordline     <= '0;
      wl_valid     <= '0;
      id_err       <= '0;
      conflict_cnt <= '0;
      hold_vld     <= '0;
      rr_ptr       <= '0;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        hold_id[c] <= '0;
      end
    end else begin
      wl_valid <= grant;
      id_err   <= cand_err;
      hold_vld <= lose;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        wordline[c*NUM_REGS +: NUM_REGS] <= grant[c] ? cand_oh[c] : '0;
        if (lose[c]) begin
          hold_id[c] <= cand_id[c];
        end
      end
      if (any_loss) begin
        rr_ptr <= rr_next;
        if (conflict_cnt != {CNT_W{1'b1}}) begin
          conflict_cnt <= conflict_cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_reg_write_port_ctrl.sv
// Self-checking bench for reg_write_port_ctrl (2 channels, 12 registers,
// 4-bit conflict counter). Honours R0_READONLY_EN if defined for the build.
module tb_reg_write_port_ctrl;

  localparam int unsigned NCH   = 2;
  localparam int unsigned NREG  = 12;
  localparam int unsigned IDW   = 4;
  localparam int unsigned CW    = 4;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NCH-1:0]       wr_valid;
  logic [NCH*IDW-1:0]   wr_id;
  logic [NCH-1:0]       wr_ready;
  logic [NCH*NREG-1:0]  wordline;
  logic [NCH-1:0]       wl_valid;
  logic [NCH-1:0]       id_err;
  logic [CW-1:0]        conflict_cnt;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  bit                   m_hold_v [NCH];
  int unsigned          m_hold_id[NCH];
  int unsigned          m_rr;
  int unsigned          m_cnt;
  logic [NCH*NREG-1:0]  e_wl;
  logic [NCH-1:0]       e_wlv;
  logic [NCH-1:0]       e_err;

  reg_write_port_ctrl #(
    .NUM_CH   (NCH),
    .NUM_REGS (NREG),
    .ID_W     (IDW),
    .CNT_W    (CW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_valid     (wr_valid),
    .wr_id        (wr_id),
    .wr_ready     (wr_ready),
    .wordline     (wordline),
    .wl_valid     (wl_valid),
    .id_err       (id_err),
    .conflict_cnt (conflict_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance the model by one clock edge given the inputs present before it.
  task automatic model_step(input logic [NCH-1:0] v, input int unsigned id0, input int unsigned id1);
    int unsigned in_id[NCH];
    bit          cv[NCH];
    int unsigned cid[NCH];
    bit          win[NCH];
    int unsigned members, w, new_rr;
    bit          found, low_found, lost_any;
    in_id[0] = id0;
    in_id[1] = id1;
    e_wl  = '0;
    e_wlv = '0;
    e_err = '0;
    if (!rst_n) begin
      for (int c = 0; c < NCH; c++) begin
        m_hold_v[c] = 0;
        m_hold_id[c] = 0;
      end
      m_rr  = 0;
      m_cnt = 0;
      return;
    end
    for (int c = 0; c < NCH; c++) begin
      cv[c] = 0;
      cid[c] = 0;
      win[c] = 0;
      if (m_hold_v[c]) begin
        cv[c] = 1;
        cid[c] = m_hold_id[c];
      end else if (v[c]) begin
        cv[c] = 1;
        cid[c] = in_id[c];
      end
      if (cv[c] && cid[c] >= NREG) begin
        e_err[c] = 1'b1;
        cv[c] = 0;
      end
`ifdef R0_READONLY_EN
      if (cv[c] && cid[c] == 0) cv[c] = 0;
`endif
    end
    low_found = 0;
    new_rr = m_rr;
    for (int unsigned r = 0; r < NREG; r++) begin
      members = 0;
      for (int c = 0; c < NCH; c++) if (cv[c] && cid[c] == r) members++;
      if (members > 0) begin
        found = 0;
        w = 0;
        for (int unsigned k = 0; k < NCH; k++) begin
          if (!found && cv[(m_rr + k) % NCH] && cid[(m_rr + k) % NCH] == r) begin
            found = 1;
            w = (m_rr + k) % NCH;
          end
        end
        win[w] = 1;
        if (members > 1 && !low_found) begin
          low_found = 1;
          new_rr = (w + 1) % NCH;
        end
      end
    end
    lost_any = 0;
    for (int c = 0; c < NCH; c++) begin
      if (win[c]) begin
        e_wlv[c] = 1'b1;
        e_wl[c*NREG + cid[c]] = 1'b1;
      end
      m_hold_v[c] = cv[c] && !win[c];
      if (m_hold_v[c]) begin
        m_hold_id[c] = cid[c];
        lost_any = 1;
      end
    end
    if (lost_any) begin
      m_rr = new_rr;
      if (m_cnt < (1 << CW) - 1) m_cnt++;
    end
  endtask

  // One clock cycle: drive, check ready, step model, check registered outputs.
  task automatic cycle(input logic [NCH-1:0] v, input int unsigned id0, input int unsigned id1);
    logic [NCH-1:0] e_rdy;
    wr_valid = v;
    wr_id    = {IDW'(id1), IDW'(id0)};
    for (int c = 0; c < NCH; c++) e_rdy[c] = rst_n & ~m_hold_v[c];
    #1;
    check("wr_ready", 64'(wr_ready), 64'(e_rdy));
    model_step(v, id0, id1);
    @(posedge clk);
    #1;
    check("wordline", 64'(wordline), 64'(e_wl));
    check("wl_valid", 64'(wl_valid), 64'(e_wlv));
    check("id_err", 64'(id_err), 64'(e_err));
    check("conflict_cnt", 64'(conflict_cnt), 64'(m_cnt));
  endtask

  initial begin
    int unsigned a, b;
    logic [1:0] rv;
    rst_n    = 1'b0;
    wr_valid = '0;
    wr_id    = '0;

    // Reset held for two edges with requests asserted
    cycle(2'b11, 3, 9);
    cycle(2'b11, 3, 9);
    check("rst_wordline", 64'(wordline), 64'h0);
    check("rst_ready", 64'(wr_ready), 64'h0);
    rst_n = 1'b1;
    cycle(2'b00, 0, 0);
    check("post_rst_wordline", 64'(wordline), 64'h0);

    // No conflict
    cycle(2'b11, 3, 9);
    check("nc_wordline", 64'(wordline), 64'h200008);
    check("nc_ready", 64'(wr_ready), 64'h3);

    // Conflict on id 5, rr_ptr = 0
    cycle(2'b11, 5, 5);
    check("cf_wordline", 64'(wordline), 64'h000020);
    check("cf_ready", 64'(wr_ready), 64'h1);
    check("cf_cnt", 64'(conflict_cnt), 64'h1);
    cycle(2'b00, 0, 0);
    check("cf_held_wordline", 64'(wordline), 64'h020000);

    // Fairness: winners alternate ch1 then ch0
    cycle(2'b11, 5, 5);
    check("fair1_wordline", 64'(wordline), 64'h020000);
    cycle(2'b00, 0, 0);
    cycle(2'b11, 5, 5);
    check("fair2_wordline", 64'(wordline), 64'h000020);
    cycle(2'b00, 0, 0);

    // Out-of-range id on ch0: error pulse, no hold
    cycle(2'b01, 13, 0);
    check("rng_err", 64'(id_err), 64'h1);
    check("rng_ready", 64'(wr_ready), 64'h3);
    cycle(2'b00, 0, 0);
    check("rng_err_pulse", 64'(id_err), 64'h0);
    cycle(2'b01, 11, 0);
    check("rng_last_ok", 64'(wordline), 64'h000800);

    // Both channels writing register 0
    cycle(2'b11, 0, 0);
`ifdef R0_READONLY_EN
    check("r0_wordline", 64'(wordline), 64'h0);
    check("r0_ready", 64'(wr_ready), 64'h3);
`endif
    cycle(2'b00, 0, 0);

    // Sustained conflicts saturate the counter
    for (int i = 0; i < 20; i++) cycle(2'b11, 7, 7);
    check("sat_cnt", 64'(conflict_cnt), 64'hF);

    // Reset mid-operation discards the held request
    rst_n = 1'b0;
    cycle(2'b00, 0, 0);
    rst_n = 1'b1;
    cycle(2'b00, 0, 0);
    check("rst_discard", 64'(wordline), 64'h0);

    // Randomized traffic, biased toward collisions and edge IDs
    for (int i = 0; i < 400; i++) begin
      rst_n = ($urandom_range(0, 59) != 0);
      rv = 2'($urandom_range(0, 3));
      a = ($urandom_range(0, 1) != 0) ? $urandom_range(4, 5) : $urandom_range(0, 15);
      b = ($urandom_range(0, 1) != 0) ? $urandom_range(4, 5) : $urandom_range(0, 15);
      cycle(rv, a, b);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
